// File: rtl/id_num_serial_tx.sv
// id_num_serial_tx: UART-style framed, LSB-first serial transmitter for a captured ID word.
// Define PARITY_EN to insert an even-parity bit between the data and stop bits.
module id_num_serial_tx #(
  parameter int DATA_W    = 20,
  parameter int BIT_TICKS = 4,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              start,
  input  logic [DATA_W-1:0] id_num,
  output logic              tx_out,
  output logic              busy,
  output logic              done
);
  localparam int TW = $clog2(BIT_TICKS + 1);
  localparam int BW = $clog2(DATA_W + 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic tx_q, tx_d, busy_q, busy_d, done_q, done_d, last_tick, last_bit, last_stop;
`ifdef PARITY_EN
  localparam state_t DATA_NEXT = PARITY;
  logic par_q, par_d;
  assign par_d = (state_q == IDLE && start) ? ^id_num : par_q;
  always_ff @(posedge clk or posedge clear)
    if (clear) par_q <= 1'b0;
    else par_q <= par_d;
`else
  localparam state_t DATA_NEXT = STOP;
`endif
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q + 1'b1;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    done_d    = 1'b0;
    last_tick = tick_q == TW'(BIT_TICKS - 1);
    last_bit  = bit_q == BW'(DATA_W - 1);
    last_stop = bit_q == BW'(STOP_BITS - 1);
    case (state_q)
      IDLE: begin
        tick_d = '0;
        bit_d  = '0;
        if (start) begin
          state_d = START;
          shreg_d = id_num;
        end
      end
      START: if (last_tick) begin
        state_d = DATA;
        tick_d  = '0;
      end
      DATA: if (last_tick) begin
        tick_d  = '0;
        shreg_d = shreg_q >> 1;
        bit_d   = last_bit ? '0 : bit_q + 1'b1;
        state_d = last_bit ? DATA_NEXT : DATA;
      end
`ifdef PARITY_EN
      PARITY: if (last_tick) begin
        state_d = STOP;
        tick_d  = '0;
      end
`endif
      STOP: if (last_tick) begin
        tick_d  = '0;
        bit_d   = last_stop ? '0 : bit_q + 1'b1;
        state_d = last_stop ? IDLE : STOP;
        done_d  = last_stop;
      end
      default: state_d = IDLE;
    endcase
    // outputs are registered, so they are derived from the state being entered
    tx_d = (state_d == START) ? 1'b0 :
           (state_d == DATA) ? shreg_d[0] :
`ifdef PARITY_EN
           (state_d == PARITY) ? par_q :
`endif
           1'b1;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or posedge clear)
    if (clear) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  assign tx_out = tx_q;
  assign busy   = busy_q;
  assign done   = done_q;
endmodule
